// File: rtl/ev_grant_if.sv
// Grant channel from USP to the EV receiver.
//   grant_valid : USP holds high while grant_msg carries an encrypted grant
//   grant_msg   : 64-bit encrypted grant
//   grant_ready : receiver is waiting for a grant; transfer when valid && ready
interface ev_grant_if;
  logic        grant_valid;
  logic [63:0] grant_msg;
  logic        grant_ready;

  modport master (
    output grant_valid,
    output grant_msg,
    input  grant_ready
  );

  modport slave (
    input  grant_valid,
    input  grant_msg,
    output grant_ready
  );
endinterface

// File: rtl/ev_grant_receiver.sv
// EV-side receiver for the USP session-grant message.
// Arms on each EV request, waits for an encrypted grant, decrypts it with a fixed
// XOR key and checks tag, EV ID and nonce echo. It then either publishes a session
// key or requests a retry. After MaxRetry retries it latches a sticky auth failure.
//   clk_i         : system clock
//   rst_ni        : synchronous active-low reset
//   ev_id_i       : local EV identity, compared with the grant's ID echo
//   ev_nonce_i    : nonce of the current request, latched on req_sent_i
//   req_sent_i    : one-cycle pulse when the EV issues a request
//   grant_if      : grant channel (valid/msg in, ready out)
//   session_key_o : key field of the last accepted grant
//   session_ok_o  : a valid session is held
//   retry_req_o   : one-cycle pulse asking the EV to re-issue its request
//   auth_fail_o   : sticky authentication failure
//   fail_code_o   : 0 none, 1 timeout, 2 bad tag, 3 ID/nonce mismatch
//   busy_o        : waiting for, checking or retrying a grant
module ev_grant_receiver #(
  parameter logic [63:0] Key      = 64'hDEAD_BEEF_CAFE_BABE,
  parameter int unsigned Timeout  = 16,
  parameter int unsigned MaxRetry = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [15:0]   ev_id_i,
  input  logic [15:0]   ev_nonce_i,
  input  logic          req_sent_i,
  ev_grant_if.slave     grant_if,
  output logic [23:0]   session_key_o,
  output logic          session_ok_o,
  output logic          retry_req_o,
  output logic          auth_fail_o,
  output logic [1:0]    fail_code_o,
  output logic          busy_o
);

  localparam logic [7:0] TimerLast = 8'(Timeout - 1);
  localparam logic [7:0] RetryMax  = 8'(MaxRetry);
  localparam logic [7:0] GoodTag   = 8'h5A;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StCheck,
    StRetry,
    StSession,
    StFail
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [7:0]  retry_cnt_q, retry_cnt_d;
  logic [15:0] exp_nonce_q, exp_nonce_d;
  logic [63:0] msg_q, msg_d;
  logic [23:0] session_key_q, session_key_d;
  logic        session_ok_q, session_ok_d;
  logic        retry_req_q, retry_req_d;
  logic        auth_fail_q, auth_fail_d;
  logic [1:0]  fail_code_q, fail_code_d;

  logic handshake;
  assign grant_if.grant_ready = (state_q == StWait);
  assign handshake = grant_if.grant_valid && grant_if.grant_ready;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    retry_cnt_d   = retry_cnt_q;
    exp_nonce_d   = exp_nonce_q;
    msg_d         = msg_q;
    session_key_d = session_key_q;
    session_ok_d  = session_ok_q;
    retry_req_d   = 1'b0;
    auth_fail_d   = auth_fail_q;
    fail_code_d   = fail_code_q;

    unique case (state_q)
      StIdle: begin
        if (req_sent_i) begin
          exp_nonce_d = ev_nonce_i;
          timer_d     = 8'd0;
          state_d     = StWait;
        end
      end
      StWait: begin
        // A handshake on the final timer cycle still wins over the timeout.
        if (handshake) begin
          msg_d   = grant_if.grant_msg ^ Key;
          state_d = StCheck;
        end else if (timer_q == TimerLast) begin
          fail_code_d = 2'd1;
          state_d     = StRetry;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StCheck: begin
        if (msg_q[7:0] != GoodTag) begin
          fail_code_d = 2'd2;
          state_d     = StRetry;
        end else if ((msg_q[63:48] != ev_id_i) || (msg_q[47:32] != exp_nonce_q)) begin
          fail_code_d = 2'd3;
          state_d     = StRetry;
        end else begin
          session_key_d = msg_q[31:8];
          session_ok_d  = 1'b1;
          fail_code_d   = 2'd0;
          retry_cnt_d   = 8'd0;
          state_d       = StSession;
        end
      end
      StRetry: begin
        if (retry_cnt_q == RetryMax) begin
          auth_fail_d = 1'b1;
          state_d     = StFail;
        end else begin
          retry_cnt_d = retry_cnt_q + 8'd1;
          retry_req_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StSession: begin
        // A new request drops the session but keeps the old key visible.
        if (req_sent_i) begin
          session_ok_d = 1'b0;
          exp_nonce_d  = ev_nonce_i;
          timer_d      = 8'd0;
          state_d      = StWait;
        end
      end
      StFail: begin
        state_d = StFail;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      timer_q       <= 8'd0;
      retry_cnt_q   <= 8'd0;
      exp_nonce_q   <= 16'd0;
      msg_q         <= 64'd0;
      session_key_q <= 24'd0;
      session_ok_q  <= 1'b0;
      retry_req_q   <= 1'b0;
      auth_fail_q   <= 1'b0;
      fail_code_q   <= 2'd0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      retry_cnt_q   <= retry_cnt_d;
      exp_nonce_q   <= exp_nonce_d;
      msg_q         <= msg_d;
      session_key_q <= session_key_d;
      session_ok_q  <= session_ok_d;
      retry_req_q   <= retry_req_d;
      auth_fail_q   <= auth_fail_d;
      fail_code_q   <= fail_code_d;
    end
  end

  assign session_key_o = session_key_q;
  assign session_ok_o  = session_ok_q;
  assign retry_req_o   = retry_req_q;
  assign auth_fail_o   = auth_fail_q;
  assign fail_code_o   = fail_code_q;
  assign busy_o        = (state_q == StWait) || (state_q == StCheck) || (state_q == StRetry);

endmodule

// File: tb/tb_ev_grant_receiver.sv
// Self-checking bench for ev_grant_receiver: directed vector table, hand-written
// multi-cycle sequences, and randomized attempts against a transaction-level model.
module tb_ev_grant_receiver;

  localparam logic [63:0] Key       = 64'hDEAD_BEEF_CAFE_BABE;
  localparam int unsigned Timeout   = 16;
  localparam int unsigned MaxRetry  = 3;
  localparam logic [63:0] GoodMsg   = 64'hDE42_120E_D8CA_ECE4;
  localparam logic [63:0] BadTagMsg = 64'hDE42_120E_D8CA_EC00;
  localparam logic [63:0] BadIdMsg  = 64'hDE43_120E_D8CA_ECE4;

  logic        clk;
  logic        rst_n;
  logic [15:0] ev_id;
  logic [15:0] ev_nonce;
  logic        req_sent;
  logic [23:0] session_key;
  logic        session_ok;
  logic        retry_req;
  logic        auth_fail;
  logic [1:0]  fail_code;
  logic        busy;

  ev_grant_if grant_if ();

  ev_grant_receiver dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .ev_id_i       (ev_id),
    .ev_nonce_i    (ev_nonce),
    .req_sent_i    (req_sent),
    .grant_if      (grant_if),
    .session_key_o (session_key),
    .session_ok_o  (session_ok),
    .retry_req_o   (retry_req),
    .auth_fail_o   (auth_fail),
    .fail_code_o   (fail_code),
    .busy_o        (busy)
  );

  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n                = 1'b0;
    req_sent             = 1'b0;
    grant_if.grant_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Request, optional idle WAIT cycles, then an optional one-cycle grant.
  // Returns after the check edge (grant) or the timeout edge (no grant).
  task automatic run_attempt(input logic [15:0] nonce, input int delay,
                             input logic [63:0] msg, input bit grant);
    ev_nonce = nonce;
    req_sent = 1'b1;
    step();
    req_sent = 1'b0;
    ev_nonce = 16'($urandom);
    repeat (delay) step();
    if (grant) begin
      grant_if.grant_valid = 1'b1;
      grant_if.grant_msg   = msg;
      step();
      grant_if.grant_valid = 1'b0;
      grant_if.grant_msg   = {$urandom, $urandom};
      step();
    end
  endtask

  // Transaction-level model: outcome of one attempt from the decrypted fields.
  logic [23:0] m_key;
  bit          m_ok, m_retry, m_auth;
  logic [1:0]  m_fc;
  int          m_fails;

  task automatic model_reset();
    m_key = '0; m_ok = 0; m_retry = 0; m_auth = 0; m_fc = '0; m_fails = 0;
  endtask

  task automatic model_attempt(input logic [63:0] msg, input logic [15:0] nonce,
                               input bit timed_out, output bit failed);
    logic [63:0] p;
    p      = msg ^ Key;
    failed = 1;
    if (timed_out) m_fc = 2'd1;
    else if (p[7:0] != 8'h5A) m_fc = 2'd2;
    else if (p[63:48] != ev_id || p[47:32] != nonce) m_fc = 2'd3;
    else failed = 0;
    if (!failed) begin
      m_key = p[31:8]; m_ok = 1; m_fc = 2'd0; m_fails = 0; m_retry = 0;
    end else begin
      m_ok = 0;
      if (m_fails == MaxRetry) begin
        m_auth = 1; m_retry = 0;
      end else begin
        m_fails++; m_retry = 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".session_ok"}, 64'(session_ok), 64'(m_ok));
    check({tag, ".session_key"}, 64'(session_key), 64'(m_key));
    check({tag, ".fail_code"}, 64'(fail_code), 64'(m_fc));
    check({tag, ".retry_req"}, 64'(retry_req), 64'(m_retry));
    check({tag, ".auth_fail"}, 64'(auth_fail), 64'(m_auth));
    check({tag, ".busy"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    string       name;
    logic [15:0] nonce;
    int          delay;
    bit          grant;
    logic [63:0] msg;
    bit          exp_ok;
    logic [23:0] exp_key;
    logic [1:0]  exp_fc;
    bit          exp_retry;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int   pulses;
    bit   failed;

    ev_id                = 16'h00EF;
    ev_nonce             = 16'h0000;
    req_sent             = 1'b0;
    rst_n                = 1'b0;
    grant_if.grant_valid = 1'b0;
    grant_if.grant_msg   = '0;

    vecs[0] = '{"good",       16'hACE1, 0,  1, GoodMsg,   1, 24'h123456, 2'd0, 0};
    vecs[1] = '{"good_late",  16'hACE1, 15, 1, GoodMsg,   1, 24'h123456, 2'd0, 0};
    vecs[2] = '{"bad_tag",    16'hACE1, 0,  1, BadTagMsg, 0, 24'h000000, 2'd2, 1};
    vecs[3] = '{"nonce_mm",   16'hACE2, 2,  1, GoodMsg,   0, 24'h000000, 2'd3, 1};
    vecs[4] = '{"id_mm",      16'hACE1, 3,  1, BadIdMsg,  0, 24'h000000, 2'd3, 1};
    vecs[5] = '{"timeout",    16'hACE1, 16, 0, GoodMsg,   0, 24'h000000, 2'd1, 1};
    vecs[6] = '{"tag_before", 16'hACE2, 1,  1, BadTagMsg, 0, 24'h000000, 2'd2, 1};

    // Reset state.
    do_reset();
    check("rst.session_ok", 64'(session_ok), 64'd0);
    check("rst.session_key", 64'(session_key), 64'd0);
    check("rst.fail_code", 64'(fail_code), 64'd0);
    check("rst.retry_req", 64'(retry_req), 64'd0);
    check("rst.auth_fail", 64'(auth_fail), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.grant_ready", 64'(grant_if.grant_ready), 64'd0);

    // Directed vector table, each from a fresh reset.
    foreach (vecs[i]) begin
      do_reset();
      run_attempt(vecs[i].nonce, vecs[i].delay, vecs[i].msg, vecs[i].grant);
      if (!vecs[i].exp_ok) step();
      check({vecs[i].name, ".session_ok"}, 64'(session_ok), 64'(vecs[i].exp_ok));
      check({vecs[i].name, ".session_key"}, 64'(session_key), 64'(vecs[i].exp_key));
      check({vecs[i].name, ".fail_code"}, 64'(fail_code), 64'(vecs[i].exp_fc));
      check({vecs[i].name, ".retry_req"}, 64'(retry_req), 64'(vecs[i].exp_retry));
      check({vecs[i].name, ".auth_fail"}, 64'(auth_fail), 64'd0);
    end

    // Latency: session_ok rises on the second edge counting the handshake edge.
    do_reset();
    ev_nonce = 16'hACE1; req_sent = 1'b1; step(); req_sent = 1'b0;
    check("lat.ready", 64'(grant_if.grant_ready), 64'd1);
    check("lat.busy_wait", 64'(busy), 64'd1);
    grant_if.grant_valid = 1'b1; grant_if.grant_msg = GoodMsg; step();
    grant_if.grant_valid = 1'b0;
    check("lat.ok_after_hs", 64'(session_ok), 64'd0);
    check("lat.busy_check", 64'(busy), 64'd1);
    check("lat.ready_check", 64'(grant_if.grant_ready), 64'd0);
    step();
    check("lat.ok", 64'(session_ok), 64'd1);
    check("lat.busy_session", 64'(busy), 64'd0);

    // Timeout boundary: nothing after 15 WAIT cycles, timeout on the 16th.
    do_reset();
    ev_nonce = 16'hACE1; req_sent = 1'b1; step(); req_sent = 1'b0;
    repeat (Timeout - 1) step();
    check("tmo.fc_early", 64'(fail_code), 64'd0);
    check("tmo.ready_early", 64'(grant_if.grant_ready), 64'd1);
    step();
    check("tmo.fc", 64'(fail_code), 64'd1);
    check("tmo.busy_retry", 64'(busy), 64'd1);
    check("tmo.retry_early", 64'(retry_req), 64'd0);
    step();
    check("tmo.retry", 64'(retry_req), 64'd1);
    check("tmo.busy_idle", 64'(busy), 64'd0);
    step();
    check("tmo.retry_pulse", 64'(retry_req), 64'd0);

    // Mismatch then success clears the retry count: three more failures only retry.
    do_reset();
    run_attempt(16'hACE2, 0, GoodMsg, 1); step();
    run_attempt(16'hACE1, 0, GoodMsg, 1);
    check("clr.ok", 64'(session_ok), 64'd1);
    for (int i = 0; i < 3; i++) begin
      run_attempt(16'hACE1, Timeout, GoodMsg, 0); step();
    end
    check("clr.retry", 64'(retry_req), 64'd1);
    check("clr.auth", 64'(auth_fail), 64'd0);
    check("clr.key_kept", 64'(session_key), 64'h123456);

    // Escalation: four timeouts give three retry pulses then auth_fail.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      run_attempt(16'hACE1, Timeout, GoodMsg, 0); step();
      if (retry_req) pulses++;
    end
    check("esc.pulses", 64'(pulses), 64'd3);
    check("esc.auth", 64'(auth_fail), 64'd1);
    req_sent = 1'b1; grant_if.grant_valid = 1'b1; grant_if.grant_msg = GoodMsg;
    repeat (4) step();
    req_sent = 1'b0; grant_if.grant_valid = 1'b0;
    step(); step();
    check("esc.auth_sticky", 64'(auth_fail), 64'd1);
    check("esc.ready", 64'(grant_if.grant_ready), 64'd0);
    check("esc.ok", 64'(session_ok), 64'd0);
    check("esc.busy", 64'(busy), 64'd0);
    check("esc.fc", 64'(fail_code), 64'd1);

    // Reset in WAIT_GRANT with a grant on the same edge: not accepted.
    do_reset();
    run_attempt(16'hACE1, 0, GoodMsg, 1);
    ev_nonce = 16'hACE1; req_sent = 1'b1; step(); req_sent = 1'b0;
    step();
    rst_n = 1'b0; grant_if.grant_valid = 1'b1; grant_if.grant_msg = GoodMsg; step();
    rst_n = 1'b1; grant_if.grant_valid = 1'b0;
    check("rstw.key", 64'(session_key), 64'd0);
    check("rstw.busy", 64'(busy), 64'd0);
    check("rstw.ready", 64'(grant_if.grant_ready), 64'd0);
    step();
    check("rstw.no_accept", 64'(busy), 64'd0);
    check("rstw.ok", 64'(session_ok), 64'd0);

    // Reset while holding a session.
    run_attempt(16'hACE1, 0, GoodMsg, 1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("rsts.ok", 64'(session_ok), 64'd0);
    check("rsts.key", 64'(session_key), 64'd0);
    check("rsts.fc", 64'(fail_code), 64'd0);

    // Randomized attempts against the transaction model.
    do_reset();
    model_reset();
    for (int n = 0; n < 300; n++) begin
      int          kind, delay;
      logic [15:0] nonce, pid, pnonce;
      logic [23:0] key;
      logic [7:0]  tag;
      logic [63:0] msg;
      bit          timed_out;
      if (m_auth || $urandom_range(0, 39) == 0) begin
        do_reset();
        model_reset();
      end
      if ($urandom_range(0, 3) == 0) ev_id = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        // Grant offered while not ready must be ignored.
        grant_if.grant_valid = 1'b1; grant_if.grant_msg = {$urandom, $urandom};
        step();
        grant_if.grant_valid = 1'b0;
        m_retry = 0;
      end
      kind   = $urandom_range(0, 4);
      nonce  = 16'($urandom);
      pid    = ev_id;
      pnonce = nonce;
      key    = 24'($urandom);
      tag    = 8'h5A;
      if (kind == 1) tag = 8'h5A ^ 8'($urandom_range(1, 255));
      if (kind == 2) pid = ev_id ^ 16'($urandom_range(1, 65535));
      if (kind == 3) pnonce = nonce ^ 16'($urandom_range(1, 65535));
      msg       = {pid, pnonce, key, tag} ^ Key;
      timed_out = (kind == 4);
      delay     = timed_out ? int'(Timeout) : int'($urandom_range(0, Timeout - 1));
      run_attempt(nonce, delay, msg, !timed_out);
      model_attempt(msg, nonce, timed_out, failed);
      if (failed) step();
      check_model($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
